// File: rtl/ts_header_monitor.sv
// ts_header_monitor: captures MPEG-2 TS headers and checks continuity counters per PID.
// Defining TS_CC_ERR_CNT_EN adds a saturating err_count output of continuity errors.
module ts_header_monitor #(
    parameter int NUM_PIDS = 8,
    parameter int PKT_LEN  = 188,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             sync_pulse,
    output logic             hdr_valid,
    output logic [12:0]      pid,
    output logic             pusi,
    output logic             tei,
    output logic [1:0]       afc,
    output logic [3:0]       cc,
    output logic             cc_error,
    output logic             table_full,
    output logic             pkt_abort,
`ifdef TS_CC_ERR_CNT_EN
    output logic [CNT_W-1:0] err_count,
`endif
    output logic [CNT_W-1:0] pkt_count
);
    localparam int IW = $clog2(PKT_LEN);
    localparam int TW = NUM_PIDS > 1 ? $clog2(NUM_PIDS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, CHECK, SKIP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic            sync_ok, abort_nx, report;
    logic [12:0]     cap_pid;
    logic            cap_tei, cap_pusi;
    logic [1:0]      cap_afc;
    logic [3:0]      cap_cc;
    logic            tab_v   [NUM_PIDS];
    logic [12:0]     tab_pid [NUM_PIDS];
    logic [3:0]      tab_cc  [NUM_PIDS];
    logic            tab_dup [NUM_PIDS];
    logic            hit, free_ok, no_check, dup_case, cc_bad, chk_err, chk_full;
    logic [TW-1:0]   hit_i, free_i;
    logic [3:0]      last_cc;

    assign sync_ok = byte_valid && sync_pulse && byte_in == 8'h47;
    assign report  = state == CHECK && !sync_ok;

    // State and byte-index register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next state: a real sync always restarts at byte 1; it aborts only while the header is unfinished
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        abort_nx = 1'b0;
        case (state)
            IDLE: begin
                if (sync_ok) begin
                    state_nx = HDR;
                    idx_nx   = IW'(1);
                end
            end
            HDR: begin
                if (sync_ok) begin
                    abort_nx = 1'b1;
                    idx_nx   = IW'(1);
                end else if (byte_valid) begin
                    state_nx = idx == IW'(3) ? CHECK : HDR;
                    idx_nx   = idx + IW'(1);
                end
            end
            CHECK: begin
                state_nx = sync_ok ? HDR : SKIP;
                idx_nx   = sync_ok ? IW'(1) : idx;
                abort_nx = sync_ok;
            end
            default: begin
                if (sync_ok) begin
                    state_nx = HDR;
                    idx_nx   = IW'(1);
                end else if (byte_valid) begin
                    state_nx = idx == IW'(PKT_LEN - 1) ? IDLE : SKIP;
                    idx_nx   = idx == IW'(PKT_LEN - 1) ? '0 : idx + IW'(1);
                end
            end
        endcase
    end

    // Header byte capture; byte1 bit5 (priority) and byte3 scrambling bits are not reported
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_pid  <= '0;
            cap_tei  <= 1'b0;
            cap_pusi <= 1'b0;
            cap_afc  <= '0;
            cap_cc   <= '0;
        end else if (state == HDR && byte_valid && !sync_ok) begin
            if (idx == IW'(1)) begin
                cap_tei       <= byte_in[7];
                cap_pusi      <= byte_in[6];
                cap_pid[12:8] <= byte_in[4:0];
            end else if (idx == IW'(2)) begin
                cap_pid[7:0] <= byte_in;
            end else if (idx == IW'(3)) begin
                cap_afc <= byte_in[5:4];
                cap_cc  <= byte_in[3:0];
            end
        end
    end

    // Table lookup: matching entry and lowest free entry
    always_comb begin
        hit     = 1'b0;
        hit_i   = '0;
        free_ok = 1'b0;
        free_i  = '0;
        for (int i = NUM_PIDS - 1; i >= 0; i--) begin
            if (tab_v[i] && tab_pid[i] == cap_pid) begin
                hit   = 1'b1;
                hit_i = TW'(i);
            end
            if (!tab_v[i]) begin
                free_ok = 1'b1;
                free_i  = TW'(i);
            end
        end
    end

    // Continuity verdict: payload packets advance the counter, one repeat is tolerated
    always_comb begin
        no_check = cap_tei || cap_pid == 13'h1FFF;
        last_cc  = tab_cc[hit_i];
        dup_case = cap_afc[0] && cap_cc == last_cc && !tab_dup[hit_i];
        cc_bad   = cap_afc[0] ? (cap_cc == last_cc ? tab_dup[hit_i] : cap_cc != last_cc + 4'd1)
                              : cap_cc != last_cc;
        chk_err  = !no_check && hit && cc_bad;
        chk_full = !no_check && !hit && !free_ok;
    end

    // PID table update at the end of CHECK; entries are only freed by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PIDS; i++) begin
                tab_v[i]   <= 1'b0;
                tab_pid[i] <= '0;
                tab_cc[i]  <= '0;
                tab_dup[i] <= 1'b0;
            end
        end else if (report && !no_check) begin
            if (hit) begin
                tab_cc[hit_i]  <= cap_cc;
                tab_dup[hit_i] <= dup_case;
            end else if (free_ok) begin
                tab_v[free_i]   <= 1'b1;
                tab_pid[free_i] <= cap_pid;
                tab_cc[free_i]  <= cap_cc;
                tab_dup[free_i] <= 1'b0;
            end
        end
    end

    // Registered header report, event pulses and packet counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_valid  <= 1'b0;
            cc_error   <= 1'b0;
            table_full <= 1'b0;
            pkt_abort  <= 1'b0;
            pid        <= '0;
            pusi       <= 1'b0;
            tei        <= 1'b0;
            afc        <= '0;
            cc         <= '0;
            pkt_count  <= '0;
        end else begin
            hdr_valid  <= report;
            cc_error   <= report && chk_err;
            table_full <= report && chk_full;
            pkt_abort  <= abort_nx;
            if (report) begin
                pid       <= cap_pid;
                pusi      <= cap_pusi;
                tei       <= cap_tei;
                afc       <= cap_afc;
                cc        <= cap_cc;
                pkt_count <= pkt_count + CNT_W'(1);
            end
        end
    end

`ifdef TS_CC_ERR_CNT_EN
    // Saturating continuity-error counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_count <= '0;
        else if (report && chk_err && err_count != '1)
            err_count <= err_count + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_ts_header_monitor.sv
// tb_ts_header_monitor: vector table, corner sequences and randomized packets against a PID-map model.
module tb_ts_header_monitor;
    localparam int NUM_PIDS = 8;
    localparam int PKT_LEN  = 188;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             byte_valid = 1'b0;
    logic             sync_pulse = 1'b0;
    logic             hdr_valid, pusi, tei, cc_error, table_full, pkt_abort;
    logic [12:0]      pid;
    logic [1:0]       afc;
    logic [3:0]       cc;
    logic [CNT_W-1:0] pkt_count;
`ifdef TS_CC_ERR_CNT_EN
    logic [CNT_W-1:0] err_count;
`endif

    ts_header_monitor #(.NUM_PIDS(NUM_PIDS), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .sync_pulse(sync_pulse),
        .hdr_valid(hdr_valid), .pid(pid), .pusi(pusi), .tei(tei), .afc(afc), .cc(cc),
        .cc_error(cc_error), .table_full(table_full), .pkt_abort(pkt_abort),
`ifdef TS_CC_ERR_CNT_EN
        .err_count(err_count),
`endif
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] pid;
        logic        tei;
        logic [1:0]  afc;
        logic [3:0]  cc;
        logic        err;
        logic        full;
    } vec_t;

    typedef struct {
        logic [12:0]      pid;
        logic             tei;
        logic             pusi;
        logic [1:0]       afc;
        logic [3:0]       cc;
        logic             err;
        logic             full;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    ev_t        log_q[$];
    int         aborts = 0;
    int         stray = 0;
    int         checks = 0;
    int         errors = 0;
    bit [3:0]   mcc[int];
    bit         mdup[int];
    int         mcnt, merr;

    always @(negedge clk) begin
        if (hdr_valid) log_q.push_back('{pid, tei, pusi, afc, cc, cc_error, table_full, pkt_count});
        if ((cc_error || table_full) && !hdr_valid) stray++;
        if (pkt_abort) aborts++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {23'd0, hdr_valid, pid, pusi, tei, afc, cc, cc_error, table_full, pkt_abort, pkt_count};
    endfunction

    task automatic drive(input logic [7:0] b, input logic s, input logic v);
        byte_in    = b;
        sync_pulse = s;
        byte_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input bit g);
        while (g && $urandom_range(0, 7) == 0) drive(8'h47, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic hdr_bytes(input logic [12:0] p, input logic t, input logic pu,
                             input logic [1:0] a, input logic [3:0] c, input bit g);
        gap(g); drive({t, pu, 1'b0, p[12:8]}, 1'b0, 1'b1);
        gap(g); drive(p[7:0], 1'b0, 1'b1);
        gap(g); drive({2'b00, a, c}, 1'b0, 1'b1);
    endtask

    task automatic payload(input int n, input bit g);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            gap(g);
            b = 8'($urandom);
            if (b == 8'h47) b = 8'h00;
            drive(b, 1'($urandom_range(0, 15) == 0), 1'b1);
        end
    endtask

    task automatic send_pkt(input logic [12:0] p, input logic t, input logic pu,
                            input logic [1:0] a, input logic [3:0] c, input bit g);
        gap(g); drive(8'h47, 1'b1, 1'b1);
        hdr_bytes(p, t, pu, a, c, g);
        payload(PKT_LEN - 4, g);
    endtask

    task automatic expect_hdr(input string tag, input logic [12:0] p, input logic t, input logic pu,
                              input logic [1:0] a, input logic [3:0] c, input logic e, input logic f,
                              input logic [CNT_W-1:0] n);
        ev_t ev;
        chk($sformatf("%s events", tag), 64'(log_q.size()), 64'd1);
        if (log_q.size() != 0) begin
            ev = log_q.pop_front();
            chk($sformatf("%s fields", tag), {ev.pid, ev.tei, ev.pusi, ev.afc, ev.cc}, {p, t, pu, a, c});
            chk($sformatf("%s cc_error", tag), ev.err, e);
            chk($sformatf("%s table_full", tag), ev.full, f);
            chk($sformatf("%s pkt_count", tag), ev.cnt, n);
        end
        log_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        log_q.delete();
        aborts = 0;
    endtask

    function automatic void model(input int p, input bit t, input bit [1:0] a, input bit [3:0] c,
                                  output bit err, output bit full);
        err  = 1'b0;
        full = 1'b0;
        if (t || p == 13'h1FFF) return;
        if (mcc.exists(p)) begin
            if (a[0]) begin
                if (c == mcc[p]) begin
                    err     = mdup[p];
                    mdup[p] = !err;
                end else begin
                    err     = c != 4'(mcc[p] + 4'd1);
                    mdup[p] = 1'b0;
                end
            end else begin
                err     = c != mcc[p];
                mdup[p] = 1'b0;
            end
            mcc[p] = c;
        end else if (mcc.num() < NUM_PIDS) begin
            mcc[p]  = c;
            mdup[p] = 1'b0;
        end else begin
            full = 1'b1;
        end
    endfunction

    vec_t tbl[27];
    int   pool[10];

    initial begin
        tbl = '{
            '{13'h100, 0, 2'b01, 4'd0,  0, 0}, '{13'h100, 0, 2'b01, 4'd1,  0, 0},
            '{13'h100, 0, 2'b01, 4'd2,  0, 0}, '{13'h101, 0, 2'b01, 4'd5,  0, 0},
            '{13'h101, 0, 2'b01, 4'd7,  1, 0}, '{13'h200, 0, 2'b01, 4'd3,  0, 0},
            '{13'h200, 0, 2'b01, 4'd3,  0, 0}, '{13'h200, 0, 2'b01, 4'd3,  1, 0},
            '{13'h300, 0, 2'b10, 4'd4,  0, 0}, '{13'h300, 0, 2'b10, 4'd4,  0, 0},
            '{13'h300, 0, 2'b10, 4'd5,  1, 0}, '{13'h1FFF, 0, 2'b01, 4'd9, 0, 0},
            '{13'h100, 1, 2'b01, 4'd9,  0, 0}, '{13'h100, 0, 2'b01, 4'd3,  0, 0},
            '{13'h400, 0, 2'b01, 4'd15, 0, 0}, '{13'h400, 0, 2'b01, 4'd0,  0, 0},
            '{13'h401, 0, 2'b11, 4'd6,  0, 0}, '{13'h401, 0, 2'b11, 4'd7,  0, 0},
            '{13'h402, 0, 2'b01, 4'd0,  0, 0}, '{13'h403, 0, 2'b01, 4'd0,  0, 0},
            '{13'h404, 0, 2'b01, 4'd0,  0, 1}, '{13'h404, 0, 2'b01, 4'd1,  0, 1},
            '{13'h1FFF, 0, 2'b00, 4'd0, 0, 0}, '{13'h100, 1, 2'b01, 4'd0,  0, 0},
            '{13'h200, 0, 2'b01, 4'd4,  0, 0}, '{13'h300, 0, 2'b00, 4'd5,  0, 0},
            '{13'h300, 0, 2'b00, 4'd6,  1, 0}
        };
        pool = '{13'h010, 13'h020, 13'h030, 13'h040, 13'h050, 13'h060, 13'h070, 13'h080, 13'h090, 13'h1FFF};

        // reset values
        drive(8'h47, 1'b1, 1'b1);
        drive(8'h47, 1'b1, 1'b1);
        chk("reset outputs", outs(), 64'd0);
`ifdef TS_CC_ERR_CNT_EN
        chk("reset err_count", 64'(err_count), 64'd0);
`endif
        rst = 1'b1;

        // header report latency, with byte_valid low after byte3
        drive(8'h47, 1'b1, 1'b1);
        hdr_bytes(13'h0AB, 1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
        chk("latency check cycle", 64'(hdr_valid), 64'd0);
        drive(8'h00, 1'b0, 1'b0);
        chk("latency hdr_valid", 64'(hdr_valid), 64'd1);
        chk("latency pid", 64'(pid), 64'h0AB);
        drive(8'h00, 1'b0, 1'b0);
        chk("latency pulse end", 64'(hdr_valid), 64'd0);
        payload(PKT_LEN - 4, 1'b0);
        chk("latency pkt_count", 64'(pkt_count), 64'd1);
        log_q.delete();

        // asynchronous reset mid-header; the remaining bytes must not produce a header
        drive(8'h47, 1'b1, 1'b1);
        drive({3'b010, 5'h01}, 1'b0, 1'b1);
        drive(8'h23, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("async reset outputs", outs(), 64'd0);
        drive(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        drive(8'h10, 1'b0, 1'b1);
        payload(PKT_LEN - 4, 1'b0);
        chk("no header after reset", 64'(log_q.size()), 64'd0);
        aborts = 0;

        // table-driven header sequence from a clean table
        merr = 0;
        for (int i = 0; i < 27; i++) begin
            send_pkt(tbl[i].pid, tbl[i].tei, 1'(i % 2), tbl[i].afc, tbl[i].cc, i % 2 == 1);
            expect_hdr($sformatf("vec%0d", i), tbl[i].pid, tbl[i].tei, 1'(i % 2), tbl[i].afc, tbl[i].cc,
                       tbl[i].err, tbl[i].full, CNT_W'(i + 1));
            if (tbl[i].err) merr++;
`ifdef TS_CC_ERR_CNT_EN
            chk($sformatf("vec%0d err_count", i), 64'(err_count), 64'(merr));
`endif
        end
        chk("no abort on sync in skip", 64'(aborts), 64'd0);

        // sync at byte2 aborts; the restarted packet reports normally
        drive(8'h47, 1'b1, 1'b1);
        drive(8'h1F, 1'b0, 1'b1);
        drive(8'h47, 1'b1, 1'b1);
        hdr_bytes(13'h1FFF, 1'b0, 1'b0, 2'b01, 4'd1, 1'b1);
        payload(PKT_LEN - 4, 1'b1);
        chk("abort at byte2", 64'(aborts), 64'd1);
        expect_hdr("abort byte2 restart", 13'h1FFF, 1'b0, 1'b0, 2'b01, 4'd1, 1'b0, 1'b0, CNT_W'(28));

        // sync during the check cycle aborts too
        drive(8'h47, 1'b1, 1'b1);
        hdr_bytes(13'h1FFF, 1'b0, 1'b0, 2'b01, 4'd2, 1'b0);
        drive(8'h47, 1'b1, 1'b1);
        hdr_bytes(13'h1FFF, 1'b0, 1'b1, 2'b01, 4'd3, 1'b0);
        payload(PKT_LEN - 4, 1'b0);
        chk("abort in check", 64'(aborts), 64'd2);
        expect_hdr("abort check restart", 13'h1FFF, 1'b0, 1'b1, 2'b01, 4'd3, 1'b0, 1'b0, CNT_W'(29));

        // randomized packets against the PID-map model
        do_reset();
        mcnt = 0;
        merr = 0;
        for (int n = 0; n < 60; n++) begin
            int       p, r;
            bit       t, pu, e, f;
            bit [1:0] a;
            bit [3:0] c;
            p  = pool[$urandom_range(0, 9)];
            t  = $urandom_range(0, 9) == 0;
            pu = 1'($urandom_range(0, 1));
            a  = 2'($urandom);
            r  = $urandom_range(0, 9);
            if (mcc.exists(p)) c = r < 6 ? 4'(mcc[p] + 4'd1) : r < 9 ? mcc[p] : 4'($urandom);
            else c = 4'($urandom);
            model(p, t, a, c, e, f);
            mcnt++;
            if (e) merr++;
            send_pkt(13'(p), t, pu, a, c, 1'($urandom_range(0, 1)));
            expect_hdr($sformatf("rnd%0d", n), 13'(p), t, pu, a, c, e, f, CNT_W'(mcnt));
        end
`ifdef TS_CC_ERR_CNT_EN
        chk("random err_count", 64'(err_count), 64'(merr));
`endif
        chk("random no aborts", 64'(aborts), 64'd0);
        chk("flags only with hdr_valid", 64'(stray), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
